// File: rtl/conv_mon_pkg.sv
// Shared types and helpers for the convergence/settling monitor.
package conv_mon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    OBSERVE,
    CHECK
  } state_e;

  // Widest sample width abs_sat can serve; callers sign-extend into this.
  localparam int ABS_MAX_W = 64;

  // Magnitude of a w-bit signed value held sign-extended in x.
  // The most negative w-bit value saturates to 2^(w-1)-1.
  function automatic logic [ABS_MAX_W-1:0] abs_sat(
    input logic signed [ABS_MAX_W-1:0] x,
    input int                          w
  );
    logic signed [ABS_MAX_W-1:0] most_neg;
    most_neg = {ABS_MAX_W{1'b1}} << (w - 1);
    if (x == most_neg) begin
      abs_sat = ~most_neg;
    end else if (x[ABS_MAX_W-1]) begin
      abs_sat = -x;
    end else begin
      abs_sat = x;
    end
  endfunction

endpackage

// File: rtl/conv_chan_chk.sv
// One monitored channel: reference sample register plus the combinational
// bound / sign / monotonic-shrink failure decision.
module conv_chan_chk
  import conv_mon_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cap_i,
  input  logic [W-1:0] sample_i,
  input  logic [W-1:0] thresh_i,
  input  logic         bound_only_i,
  input  logic         mono_en_i,
  input  logic         sign_en_i,
  input  logic         exp_neg_i,
  output logic         fail_o
);

  logic [W-1:0]           ref_q;
  logic [ABS_MAX_W-1:0]   mag_cur;
  logic [ABS_MAX_W-1:0]   mag_ref;
  logic [ABS_MAX_W-1:0]   thresh_ext;
  logic                   bound_bad;
  logic                   sign_bad;
  logic                   mono_bad;

  // NOTE: state uses <= so every flop samples pre-edge values; the reference
  // is a single register, so clearing it on reset is cheap and keeps runs
  // after reset deterministic.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ref_q <= '0;
    end else if (cap_i) begin
      ref_q <= sample_i;
    end
  end

  assign mag_cur    = abs_sat({{(ABS_MAX_W-W){sample_i[W-1]}}, sample_i}, W);
  assign mag_ref    = abs_sat({{(ABS_MAX_W-W){ref_q[W-1]}}, ref_q}, W);
  assign thresh_ext = {{(ABS_MAX_W-W){1'b0}}, thresh_i};

  // Magnitudes never exceed 2^(W-1)-1, so the wide compare equals a W-bit
  // unsigned compare.
  assign bound_bad = (mag_cur >= thresh_ext);
  assign sign_bad  = exp_neg_i ? ~ref_q[W-1] : (ref_q[W-1] | (ref_q == '0));
  assign mono_bad  = (mag_cur >= mag_ref);

  assign fail_o = bound_bad
                | (~bound_only_i & sign_en_i & sign_bad)
                | (~bound_only_i & mono_en_i & mono_bad);

endmodule

// File: rtl/conv_monitor.sv
// Convergence/settling monitor: settle, capture references, observe, then
// check every channel for bound, sign and monotonic shrink.
module conv_monitor
  import conv_mon_pkg::*;
#(
  parameter int N_CH       = 2,
  parameter int W          = 16,
  parameter int SETTLE_CYC = 100000,
  parameter int OBS_CYC    = 800000,
  parameter int CNT_W      = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              bound_only,
  input  logic [N_CH*W-1:0] samples,
  input  logic [W-1:0]      thresh,
  input  logic [N_CH-1:0]   mono_mask,
  input  logic [N_CH-1:0]   sign_mask,
  input  logic [N_CH-1:0]   exp_neg,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_CH-1:0]   fail_mask
);

  localparam longint MAX_CYC = (SETTLE_CYC > OBS_CYC) ? SETTLE_CYC : OBS_CYC;

  if (SETTLE_CYC == 0 || OBS_CYC == 0) begin : g_bad_cyc
    $error("conv_monitor: SETTLE_CYC and OBS_CYC must be non-zero");
  end
  if ((longint'(1) << CNT_W) <= MAX_CYC) begin : g_bad_cnt
    $error("conv_monitor: CNT_W too narrow for SETTLE_CYC/OBS_CYC");
  end
  if (W < 2 || W >= ABS_MAX_W) begin : g_bad_w
    $error("conv_monitor: W out of supported range");
  end

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] OBS_LAST    = CNT_W'(OBS_CYC - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic [N_CH-1:0]   fail_q;
  logic              bound_only_q;
  logic [W-1:0]      thresh_q;
  logic [N_CH-1:0]   mono_mask_q;
  logic [N_CH-1:0]   sign_mask_q;
  logic [N_CH-1:0]   exp_neg_q;
  logic [N_CH-1:0]   chan_fail;
  logic              capture;

  assign capture = (state_q == SETTLE) && (cnt_q == SETTLE_LAST);

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    conv_chan_chk #(
      .W (W)
    ) u_chk (
      .clk          (clk),
      .rst_n        (rst_n),
      .cap_i        (capture),
      .sample_i     (samples[i*W +: W]),
      .thresh_i     (thresh_q),
      .bound_only_i (bound_only_q),
      .mono_en_i    (mono_mask_q[i]),
      .sign_en_i    (sign_mask_q[i]),
      .exp_neg_i    (exp_neg_q[i]),
      .fail_o       (chan_fail[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= '0;
      bound_only_q <= 1'b0;
      thresh_q     <= '0;
      mono_mask_q  <= '0;
      sign_mask_q  <= '0;
      exp_neg_q    <= '0;
    end else begin
      done_q <= 1'b0;
      // A start in any state, including CHECK, begins a fresh run.
      if (start) begin
        bound_only_q <= bound_only;
        thresh_q     <= thresh;
        mono_mask_q  <= mono_mask;
        sign_mask_q  <= sign_mask;
        exp_neg_q    <= exp_neg;
        pass_q       <= 1'b0;
        fail_q       <= '0;
        cnt_q        <= '0;
        busy_q       <= 1'b1;
        state_q      <= SETTLE;
      end else begin
        case (state_q)
          IDLE: begin
            cnt_q <= '0;
          end
          SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
              cnt_q   <= '0;
              state_q <= OBSERVE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          OBSERVE: begin
            if (cnt_q == OBS_LAST) begin
              cnt_q   <= '0;
              state_q <= CHECK;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          CHECK: begin
            fail_q  <= chan_fail;
            pass_q  <= ~|chan_fail;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_mask = fail_q;

endmodule

// File: tb/tb_conv_monitor.sv
// Randomised plus directed bench for conv_monitor with a queue scoreboard
// and an arithmetic reference model of the per-channel rules.
module tb_conv_monitor;

  localparam int N_CH       = 2;
  localparam int W          = 16;
  localparam int SETTLE_CYC = 8;
  localparam int OBS_CYC    = 16;
  localparam int CNT_W      = 20;
  localparam int LATENCY    = SETTLE_CYC + OBS_CYC + 1;

  typedef struct {
    logic [15:0] cap0, cap1, chk0, chk1, th;
    logic        bo;
    logic [1:0]  mm, sm, en;
  } run_t;

  typedef struct {
    int         cyc;
    logic [1:0] fm;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              bound_only;
  logic [N_CH*W-1:0] samples;
  logic [W-1:0]      thresh;
  logic [N_CH-1:0]   mono_mask;
  logic [N_CH-1:0]   sign_mask;
  logic [N_CH-1:0]   exp_neg;
  logic              busy;
  logic              done;
  logic              pass;
  logic [N_CH-1:0]   fail_mask;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t sb[$];

  conv_monitor #(
    .N_CH       (N_CH),
    .W          (W),
    .SETTLE_CYC (SETTLE_CYC),
    .OBS_CYC    (OBS_CYC),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .bound_only (bound_only),
    .samples    (samples),
    .thresh     (thresh),
    .mono_mask  (mono_mask),
    .sign_mask  (sign_mask),
    .exp_neg    (exp_neg),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail_mask  (fail_mask)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the channel rules.
  function automatic int mag(input logic [15:0] x);
    int v;
    v = int'($signed(x));
    if (v == -32768) return 32767;
    return (v < 0) ? -v : v;
  endfunction

  function automatic bit chan_fails(input logic [15:0] r, input logic [15:0] c,
                                    input logic bo, input logic m, input logic s,
                                    input logic n, input logic [15:0] th);
    int  rv;
    bit  f;
    rv = int'($signed(r));
    f  = (mag(c) >= int'(th));
    if (!bo && s) f = f | (n ? (rv >= 0) : (rv <= 0));
    if (!bo && m) f = f | (mag(c) >= mag(r));
    return f;
  endfunction

  function automatic logic [1:0] model(input run_t r);
    logic [1:0] fm;
    fm[0] = chan_fails(r.cap0, r.chk0, r.bo, r.mm[0], r.sm[0], r.en[0], r.th);
    fm[1] = chan_fails(r.cap1, r.chk1, r.bo, r.mm[1], r.sm[1], r.en[1], r.th);
    return fm;
  endfunction

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(cyc), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_cycle", 32'(cyc), 32'(e.cyc));
        check("fail_mask", 32'(fail_mask), 32'(e.fm));
        check("pass", 32'(pass), 32'(e.fm == 2'b00));
        check("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  // Called at a negedge; the following posedge samples start.
  task automatic drive_start(input run_t r, input bit expect_done);
    exp_t e;
    start      = 1'b1;
    bound_only = r.bo;
    thresh     = r.th;
    mono_mask  = r.mm;
    sign_mask  = r.sm;
    exp_neg    = r.en;
    samples    = {r.cap1, r.cap0};
    if (expect_done) begin
      e.cyc = cyc + 1 + LATENCY;
      e.fm  = model(r);
      sb.push_back(e);
    end
    @(negedge clk);
    start      = 1'b0;
    bound_only = 1'($urandom);
    thresh     = 16'($urandom);
    mono_mask  = 2'($urandom);
    sign_mask  = 2'($urandom);
    exp_neg    = 2'($urandom);
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  // Called at the negedge after the start edge: swap to check-time samples
  // once the references are captured, then wait for the result.
  task automatic finish_run(input run_t r);
    repeat (SETTLE_CYC) @(negedge clk);
    samples = {r.chk1, r.chk0};
    for (int k = 0; k < 3 * LATENCY; k++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
      #1;
    end
    check("result_arrived", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic run(input run_t r);
    @(negedge clk);
    drive_start(r, 1'b1);
    finish_run(r);
  endtask

  task automatic restart(input run_t first, input run_t second, input int gap);
    @(negedge clk);
    drive_start(first, 1'b0);
    repeat (gap - 1) @(negedge clk);
    drive_start(second, 1'b1);
    finish_run(second);
  endtask

  function automatic logic [15:0] rnd_sample();
    case ($urandom_range(0, 4))
      0: return 16'($urandom);
      1: return 16'($urandom_range(0, 6000) - 3000);
      2: return 16'h8000;
      3: return 16'h0000;
      default: return 16'($urandom_range(0, 4200) - 2100);
    endcase
  endfunction

  function automatic run_t base_run();
    run_t r;
    r.cap0 = -16'sd1500; r.chk0 = -16'sd200;
    r.cap1 = 16'd100;    r.chk1 = 16'd100;
    r.th   = 16'h0800;   r.bo   = 1'b0;
    r.mm   = 2'b01;      r.sm   = 2'b01; r.en = 2'b01;
    return r;
  endfunction

  initial begin
    run_t r;
    run_t r2;
    rst_n = 1'b0; start = 1'b0; bound_only = 1'b0; samples = '0;
    thresh = '0; mono_mask = '0; sign_mask = '0; exp_neg = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_fail_mask", 32'(fail_mask), 32'd0);
    rst_n = 1'b1;

    // Converging backward, wrong sign, diverging, equal magnitude.
    r = base_run();
    run(r);
    r.cap0 = 16'd1500;
    run(r);
    r = base_run(); r.cap0 = -16'sd300; r.chk0 = -16'sd900;
    run(r);
    r.chk0 = -16'sd300;
    run(r);

    // Bound-only balance checks, saturating magnitude, zero threshold.
    r = base_run(); r.bo = 1'b1;
    r.cap0 = -16'sh0100; r.chk0 = -16'sh0100;
    r.cap1 = 16'h0900;   r.chk1 = 16'h0900;
    run(r);
    r.cap0 = 16'h8000; r.chk0 = 16'h8000;
    run(r);
    r = base_run(); r.th = 16'h0000;
    run(r);

    // Restart mid-settle/observe and restart coincident with CHECK.
    r = base_run(); r.cap0 = 16'd1500;
    r2 = base_run();
    restart(r, r2, 10);
    restart(r2, r, LATENCY);

    // Reset during OBSERVE aborts silently.
    @(negedge clk);
    drive_start(base_run(), 1'b0);
    repeat (SETTLE_CYC + 4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_fail_mask", 32'(fail_mask), 32'd0);
    rst_n = 1'b1;
    repeat (2 * LATENCY) @(negedge clk);
    check("midrst_idle", 32'(busy), 32'd0);

    // Randomised runs.
    for (int n = 0; n < 40; n++) begin
      r.cap0 = rnd_sample(); r.cap1 = rnd_sample();
      r.chk0 = rnd_sample(); r.chk1 = rnd_sample();
      case ($urandom_range(0, 3))
        0: r.th = 16'h0000;
        1: r.th = 16'hFFFF;
        default: r.th = 16'($urandom_range(0, 5000));
      endcase
      r.bo = ($urandom_range(0, 3) == 0);
      r.mm = 2'($urandom); r.sm = 2'($urandom); r.en = 2'($urandom);
      run(r);
    end

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout actual=%0d expected=finished", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/conv_monitor.md
Name: conv_monitor

Overview:
- Synthesizable, parametrised convergence/settling checker for N signed telemetry channels, e.g. platform theta, platform omega and wheel omegas.
- Replaces ad-hoc bench checks with a reusable block, usable in benches and on-chip as a self-test/fault monitor beside the balance controller.
- On each start pulse (e.g. a rider_lean step): waits a settle window, captures per-channel reference samples, waits an observe window, then checks sign, monotonic shrink and bound per channel.
- Also supports a bound-only mode for steady-state balancing checks.

Parameters:
- N_CH, 2, number of monitored channels.
- W, 16, signed sample width per channel.
- SETTLE_CYC, 100000, cycles from start to reference capture.
- OBS_CYC, 800000, cycles from reference capture to check.
- CNT_W, 20, counter width; must satisfy 2^CNT_W > max(SETTLE_CYC, OBS_CYC).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse that begins a check run.
- bound_only  in  1  latched at start; 1 = bound check only.
- samples  in  N_CH*W  packed signed samples; channel i at [i*W +: W].
- thresh  in  W  unsigned magnitude bound, latched at start.
- mono_mask  in  N_CH  channels that must shrink in magnitude, latched at start.
- sign_mask  in  N_CH  channels whose reference sample sign is checked, latched at start.
- exp_neg  in  N_CH  expected reference sign (1 = negative), latched at start.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse when the check completes.
- pass  out  1  1 when fail_mask == 0; held until the next start.
- fail_mask  out  N_CH  per-channel failure flags; held until the next start.

Behaviour:
- Reset (synchronous, rst_n low at posedge clk): state IDLE, busy=0, done=0, pass=0, fail_mask=0, counters and reference registers cleared. Reset mid-run aborts the run; no done pulse is produced.
- FSM states: IDLE, SETTLE, OBSERVE, CHECK.
  - IDLE: on start, latch config inputs, clear pass/fail_mask, load counter to 0, go to SETTLE. busy=1 from the following cycle.
  - SETTLE: counter increments each cycle. When counter == SETTLE_CYC-1: capture ref[i] = samples[i] for all channels, reset counter, go to OBSERVE.
  - OBSERVE: when counter == OBS_CYC-1, go to CHECK.
  - CHECK (one cycle): evaluate samples, register fail_mask and pass, pulse done, busy=0, return to IDLE.
- Latency: done asserts SETTLE_CYC+OBS_CYC+1 cycles after the start cycle.
- start while busy: abort and restart from SETTLE with newly latched config. The restart does not pulse done. start coincident with CHECK also restarts, and that check result is discarded.
- Magnitude: abs_sat(x) = -x for negative x, saturating the most negative value to 2^(W-1)-1. Comparisons are unsigned on W bits.
- Per-channel failure, evaluated in CHECK on current sample c and reference r:
  - Bound: abs_sat(c) >= thresh (always applied).
  - Sign (not bound_only and sign_mask[i]): exp_neg[i] ? (r >= 0) : (r <= 0).
  - Monotonic (not bound_only and mono_mask[i]): abs_sat(c) >= abs_sat(r). Equal magnitude is a failure.
- thresh == 0: every channel fails the bound check.
- SETTLE_CYC or OBS_CYC == 0: illegal; checked by an elaboration-time assertion.

Decomposition:
- Shared package conv_mon_pkg holds:
  - state enum {IDLE, SETTLE, OBSERVE, CHECK};
  - abs_sat function, parametrised via W.
- One sub-module, conv_chan_chk, holds the per-channel reference register plus the combinational fail logic. It is instantiated N_CH times with a generate loop; the top keeps the FSM, counter and config latches.

Test Plan:
Common setup for all cases: N_CH=2, W=16, SETTLE_CYC=8, OBS_CYC=16, thresh=16'h0800.
- Converge backward: ch0 = -16'd1500 at capture, then -16'd200 at check; ch1 = 16'd100 throughout. Config mono_mask=01, sign_mask=01, exp_neg=01. Required: done at cycle 25, pass=1, fail_mask=00.
- Wrong sign: same as converge backward but ch0 = +16'd1500 at capture. Required: fail_mask=01, pass=0.
- Diverging: ch0 goes -16'd300 -> -16'd900. Required: fail_mask=01. Repeat with ch0 = -16'd300 at both capture and check (equal magnitude). Required: fail_mask=01.
- Bound-only balance: bound_only=1, ch1 = 16'h0900, ch0 = -16'h0100. Required: fail_mask=10. Repeat with ch0 = 16'h8000 (abs saturates to 16'h7FFF). Required: fail_mask=11.
- Restart and reset: start again at cycle 10. Required: no done at cycle 25; done at cycle 35. Also assert rst_n=0 during OBSERVE. Required: busy=0 next cycle and no done pulse.
